dmem_io_bridge: RTL and testbench

Memory-mapped I/O bridge sitting directly downstream of the processor's data-memory port (`dmem_addr`/`dmem_data_out`/`dmem_wr`/`dmem_data_in`). It passes ordinary accesses through to the data RAM and decodes the top 256-byte page as I/O. The I/O page holds an 8-deep transmit FIFO, status and counter registers, and an 8N1 UART serializer, so firmware can print bytes with plain stores.

---
 rtl/dmem_io_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_io_bridge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_io_bridge.sv
// Data-memory port bridge: RAM pass-through plus an I/O page at 0xFFxx holding
// a byte TX FIFO, status/frame-counter registers and an 8N1 UART serializer.
module dmem_io_bridge #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_wr,
    output logic [31:0] cpu_rdata,
    output logic [15:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_wr,
    input  logic [31:0] ram_rdata,
    output logic        uart_tx
);

    localparam int BCW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [BCW-1:0]   BIT_LAST = BCW'(CLK_DIV - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [3:0]       CNT_FULL = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic             w_io_sel;
    logic             w_io_wr;
    logic             w_wr_pulse;
    logic             w_push;
    logic             w_push_acc;
    logic             w_stat_wr;
    logic             w_cnt_wr;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_active;
    logic             w_bit_end;
    logic             w_frame_done;
    logic             w_tx_nxt;
    logic [31:0]      w_status;
    logic [31:0]      w_io_rdata;
    state_t           w_state_nxt;
    logic [BCW-1:0]   w_bcnt_nxt;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       w_shift_nxt;

    logic             r_wr_prev;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [3:0]       r_count;
    logic             r_ovf;
    state_t           r_state;
    logic [BCW-1:0]   r_bcnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic [31:0]      r_txcount;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_io_sel  = (cpu_addr[15:8] == 8'hFF);
    assign ram_addr  = cpu_addr;
    assign ram_wdata = cpu_wdata;
    assign ram_wr    = cpu_wr & ~w_io_sel;

    // One action per store: act only on the rising edge of the qualified strobe.
    assign w_io_wr    = cpu_wr & w_io_sel;
    assign w_wr_pulse = w_io_wr & ~r_wr_prev;
    assign w_push     = w_wr_pulse && (cpu_addr[7:0] == 8'h00);
    assign w_stat_wr  = w_wr_pulse && (cpu_addr[7:0] == 8'h01);
    assign w_cnt_wr   = w_wr_pulse && (cpu_addr[7:0] == 8'h02);

    assign w_empty    = (r_count == 4'd0);
    assign w_full     = (r_count == CNT_FULL);
    assign w_active   = (r_state != S_IDLE);
    assign w_push_acc = w_push && (!w_full || w_pop);
    assign w_bit_end  = (r_bcnt == BIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_prev <= 1'b0;
        end else begin
            r_wr_prev <= w_io_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wptr] <= cpu_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 4'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push_acc, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            // A dropped byte wins over a same-cycle clear.
            if (w_push && !w_push_acc) begin
                r_ovf <= 1'b1;
            end else if (w_stat_wr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bcnt_nxt   = w_bit_end ? '0 : r_bcnt + 1'b1;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_pop        = 1'b0;
        w_frame_done = 1'b0;
        w_tx_nxt     = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_bcnt_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rptr];
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Line level is registered from the next state so uart_tx never glitches.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bcnt    <= '0;
            r_idx     <= 3'd0;
            r_tx      <= 1'b1;
            r_txcount <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            if (w_cnt_wr) begin
                r_txcount <= 32'd0;
            end else if (w_frame_done) begin
                r_txcount <= r_txcount + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    assign uart_tx  = r_tx;
    assign w_status = {24'd0, r_count, r_ovf, w_active, w_full, w_empty};

    always_comb begin
        w_io_rdata = 32'd0;
        case (cpu_addr[7:0])
            8'h01:   w_io_rdata = w_status;
            8'h02:   w_io_rdata = r_txcount;
            default: w_io_rdata = 32'd0;
        endcase
    end

    assign cpu_rdata = w_io_sel ? w_io_rdata : ram_rdata;

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Bench for dmem_io_bridge: a frame-timer/queue model checked every cycle,
// plus directed stores and literal expectations for each scenario.
module tb_dmem_io_bridge;

    localparam int D     = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [31:0] cpu_wdata = 32'd0;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_rdata;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wr;
    logic [31:0] ram_rdata;
    logic        uart_tx;

    dmem_io_bridge #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wr    (cpu_wr),
        .cpu_rdata (cpu_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wr    (ram_wr),
        .ram_rdata (ram_rdata),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:255];
    assign ram_rdata = ram[ram_addr[7:0]];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        forever begin
            @(posedge clk);
            if (ram_wr) ram[ram_addr[7:0]] = ram_wdata;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: a byte queue, a busy flag and a cycle index into the current 10*D frame.
    logic [7:0]  m_q [$];
    bit          m_busy, m_ovf, m_prev;
    int          m_t;
    logic [7:0]  m_byte;
    logic [31:0] m_txcnt;
    bit          mi_io, mi_q, mi_pulse, mi_push, mi_sw, mi_cw, mi_pop, mi_full, mi_acc;

    function automatic logic m_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / D;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    function automatic logic [31:0] m_rd();
        if (cpu_addr[15:8] != 8'hFF) return ram[cpu_addr[7:0]];
        case (cpu_addr[7:0])
            8'h01:   return {24'd0, 4'(m_q.size()), m_ovf, m_busy,
                             (m_q.size() == DEPTH), (m_q.size() == 0)};
            8'h02:   return m_txcnt;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        m_busy = 0; m_ovf = 0; m_prev = 0; m_t = 0; m_txcnt = 0; m_byte = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_q.delete();
                m_busy = 0; m_ovf = 0; m_prev = 0; m_t = 0; m_txcnt = 0;
            end else begin
                mi_io    = (cpu_addr[15:8] == 8'hFF);
                mi_q     = cpu_wr && mi_io;
                mi_pulse = mi_q && !m_prev;
                m_prev   = mi_q;
                mi_push  = mi_pulse && (cpu_addr[7:0] == 8'h00);
                mi_sw    = mi_pulse && (cpu_addr[7:0] == 8'h01);
                mi_cw    = mi_pulse && (cpu_addr[7:0] == 8'h02);
                mi_pop   = !m_busy && (m_q.size() > 0);
                mi_full  = (m_q.size() == DEPTH);
                mi_acc   = mi_push && (!mi_full || mi_pop);
                if (mi_pop) begin
                    m_byte = m_q.pop_front();
                    m_busy = 1; m_t = 0;
                end else if (m_busy) begin
                    if (m_t == 10*D-1) begin
                        m_busy = 0;
                        m_txcnt = m_txcnt + 32'd1;
                    end else begin
                        m_t++;
                    end
                end
                if (mi_acc) m_q.push_back(cpu_wdata[7:0]);
                if (mi_push && !mi_acc) m_ovf = 1;
                else if (mi_sw) m_ovf = 0;
                if (mi_cw) m_txcnt = 32'd0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !reset) begin
                chk("uart_tx", {31'd0, uart_tx}, {31'd0, m_tx()});
                chk("cpu_rdata", cpu_rdata, m_rd());
                chk("ram_wr", {31'd0, ram_wr}, {31'd0, cpu_wr & (cpu_addr[15:8] != 8'hFF)});
                chk("ram_addr", {16'd0, ram_addr}, {16'd0, cpu_addr});
                chk("ram_wdata", ram_wdata, cpu_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [31:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        tick();
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [31:0] exp);
        cpu_addr = a; cpu_wr = 1'b0;
        @(negedge clk);
        chk(name, cpu_rdata, exp);
        tick();
    endtask

    logic [9:0] pat;
    logic [3:0] smp;
    bit         seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pat = 10'b1101001010;  // 0xA5 framed: start, LSB..MSB, stop
        repeat (3) tick();
        reset = 1'b0;
        chk_en = 1'b1;
        rd("reset_status", 16'hFF01, 32'h0000_0001);
        rd("reset_txcount", 16'hFF02, 32'h0);
        chk("reset_uart", {31'd0, uart_tx}, 32'd1);

        cpu_addr = 16'h0040; cpu_wdata = 32'h1234_5678; cpu_wr = 1'b1;
        @(negedge clk);
        chk("ram_wr_pulse", {31'd0, ram_wr}, 32'd1);
        tick();
        cpu_wr = 1'b0;
        rd("ram_readback", 16'h0040, 32'h1234_5678);
        chk("ram_uart_idle", {31'd0, uart_tx}, 32'd1);

        rd("unmapped_read", 16'hFF10, 32'h0);
        store(16'hFF10, 32'hFFFF_FFFF);
        rd("txdata_read", 16'hFF00, 32'h0);

        cpu_addr = 16'hFF00; cpu_wdata = 32'h0000_00A5; cpu_wr = 1'b1;
        @(posedge clk);
        #1;
        cpu_wr = 1'b0; cpu_addr = 16'hFF02;
        @(negedge clk);
        chk("pre_start_uart", {31'd0, uart_tx}, 32'd1);
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                smp[j] = uart_tx;
            end
            chk($sformatf("a5_bit%0d", b), {28'd0, smp}, {28'd0, {4{pat[b]}}});
        end
        chk("txcount_before_end", cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("txcount_after_40", cpu_rdata, 32'd1);
        cpu_addr = 16'hFF01;
        #1;
        chk("active_dropped", cpu_rdata, 32'h0000_0001);

        for (int i = 0; i < 10; i++) store(16'hFF00, 32'h10 + i);
        rd("overflow_status", 16'hFF01, 32'h0000_008E);
        store(16'hFF01, 32'h0);
        rd("overflow_cleared", 16'hFF01, 32'h0000_0086);

        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) seen = 1'b1;
        end
        if (!seen) chk("reset_wait_low", {31'd0, uart_tx}, 32'd0);
        #2 reset = 1'b1;
        #1 chk("reset_async_uart", {31'd0, uart_tx}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        rd("midframe_reset_status", 16'hFF01, 32'h0000_0001);
        rd("midframe_reset_txcount", 16'hFF02, 32'h0);

        cpu_addr = 16'hFF00; cpu_wdata = 32'h0000_003C; cpu_wr = 1'b1;
        repeat (5) tick();
        cpu_wr = 1'b0;
        rd("held_status", 16'hFF01, 32'h0000_0005);
        repeat (45) tick();
        rd("held_frames", 16'hFF02, 32'd1);
        store(16'hFF02, 32'h0);
        rd("txcount_zeroed", 16'hFF02, 32'd0);

        store(16'hFF00, 32'h01);
        store(16'hFF00, 32'h80);
        store(16'hFF00, 32'hFF);
        repeat (130) tick();
        rd("drain_txcount", 16'hFF02, 32'd3);
        rd("drain_status", 16'hFF01, 32'h0000_0001);
        store(16'hFF02, 32'h7);
        rd("txcount_clear", 16'hFF02, 32'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
